// File: rtl/vdp1_pix_color_pipe_if.sv
// Pixel stream, background-read and output-FIFO signals of the VDP1 pixel colour pipe.
// master = rasteriser/framebuffer side, slave = the pipe itself.
interface vdp1_pix_color_pipe_if #(
  parameter int PIX_W     = 16,
  parameter int GOUR_FRAC = 0
);
  logic                         in_valid;
  logic                         in_ready;
  logic [15:0]                  in_data;
  logic [2:0]                   in_cm;
  logic [1:0]                   in_offsx;
  logic [15:0]                  in_colr;
  logic                         in_spd;
  logic                         in_ecd;
  logic                         in_mesh;
  logic [2:0]                   in_ccb;
  logic [3*(5+GOUR_FRAC)-1:0]   in_cg;
  logic [9:0]                   in_x;
  logic [8:0]                   in_y;
  logic                         in_last;

  logic                         bk_req;
  logic [9:0]                   bk_x;
  logic [8:0]                   bk_y;
  logic                         bk_ack;
  logic [15:0]                  bk_data;

  logic                         out_valid;
  logic                         out_ready;
  logic [9:0]                   out_x;
  logic [8:0]                   out_y;
  logic [PIX_W-1:0]             out_data;

  modport master (
    output in_valid, in_data, in_cm, in_offsx, in_colr, in_spd, in_ecd, in_mesh,
           in_ccb, in_cg, in_x, in_y, in_last,
    input  in_ready,
    input  bk_req, bk_x, bk_y,
    output bk_ack, bk_data,
    input  out_valid, out_x, out_y, out_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_data, in_cm, in_offsx, in_colr, in_spd, in_ecd, in_mesh,
           in_ccb, in_cg, in_x, in_y, in_last,
    output in_ready,
    output bk_req, bk_x, bk_y,
    input  bk_ack, bk_data,
    output out_valid, out_x, out_y, out_data,
    input  out_ready
  );
endinterface

// File: rtl/vdp1_pix_color_pipe.sv
// VDP1 pixel back-end: decode/discard (D), background read (B), Gouraud + colour calc (C),
// then an output FIFO. Admission is throttled so the FIFO can never overflow.
module vdp1_pix_color_pipe #(
  parameter int DEPTH     = 4,
  parameter int PIX_W     = 16,
  parameter int GOUR_FRAC = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  vdp1_pix_color_pipe_if.slave        pix,
  input  logic                        clr,
  output logic [15:0]                 pix_out,
  output logic [15:0]                 pix_disc,
  output logic                        done
);
  localparam int GW = 5 + GOUR_FRAC;
  localparam int CW = 3 * GW;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 3;
  localparam int EW = PIX_W + 20;

  // stage D
  logic          d_valid_reg;
  logic [15:0]   d_data_reg, d_colr_reg;
  logic [2:0]    d_cm_reg, d_ccb_reg;
  logic [1:0]    d_offsx_reg;
  logic          d_spd_reg, d_ecd_reg, d_mesh_reg, d_last_reg;
  logic [CW-1:0] d_cg_reg;
  logic [9:0]    d_x_reg;
  logic [8:0]    d_y_reg;
  // stage B
  logic          b_valid_reg, b_calc_reg, b_need_reg, b_last_reg, bk_req_reg;
  logic [15:0]   b_col_reg;
  logic [2:0]    b_ccb_reg;
  logic [CW-1:0] b_cg_reg;
  logic [9:0]    b_x_reg;
  logic [8:0]    b_y_reg;
  // stage C
  logic             c_valid_reg, c_last_reg;
  logic [PIX_W-1:0] c_data_reg;
  logic [9:0]       c_x_reg;
  logic [8:0]       c_y_reg;
  // FIFO
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [EW-1:0] head;
  logic [15:0]   pix_out_reg, pix_disc_reg;
  logic          done_reg;

  logic [3:0]  nib;
  logic [7:0]  byte_sel;
  logic [15:0] d_col;
  logic        tp, ec, d_discard, d_calc, d_need;
  logic        bk_fire, b_adv, b_free, d_adv, d_drop, b_load, accept, pop;
  logic [OW-1:0] occupancy;
  logic [14:0] calc_rgb;
  logic        calc_msb;
  logic [15:0] c_next;

  // ---------------- decode and discard ----------------
  always_comb begin
    case (d_offsx_reg)
      2'd0:    nib = d_data_reg[15:12];
      2'd1:    nib = d_data_reg[11:8];
      2'd2:    nib = d_data_reg[7:4];
      default: nib = d_data_reg[3:0];
    endcase
    byte_sel = d_offsx_reg[1] ? d_data_reg[7:0] : d_data_reg[15:8];
    d_col    = d_data_reg;
    tp       = ~d_data_reg[15];
    ec       = (d_data_reg == 16'h7FFF);
    case (d_cm_reg)
      3'd0, 3'd1: begin
        d_col = {d_colr_reg[15:4], nib};
        tp    = (nib == 4'h0);
        ec    = &nib;
      end
      3'd2: begin
        d_col = {d_colr_reg[15:6], byte_sel[5:0]};
        tp    = (byte_sel == 8'h00);
        ec    = &byte_sel;
      end
      3'd3: begin
        d_col = {d_colr_reg[15:7], byte_sel[6:0]};
        tp    = (byte_sel == 8'h00);
        ec    = &byte_sel;
      end
      3'd4: begin
        d_col = {d_colr_reg[15:8], byte_sel};
        tp    = (byte_sel == 8'h00);
        ec    = &byte_sel;
      end
      default: ;
    endcase
    d_discard = (tp & ~d_spd_reg) | (ec & ~d_ecd_reg) | (d_mesh_reg & (d_x_reg[0] ^ d_y_reg[0]));
    d_calc    = (d_cm_reg >= 3'd5) && (PIX_W == 16);
    d_need    = d_calc & d_ccb_reg[0];
  end

  // ---------------- pipeline flow control ----------------
  assign bk_fire = bk_req_reg & pix.bk_ack;
  assign b_adv   = b_valid_reg & (~b_need_reg | bk_fire);
  assign b_free  = ~b_valid_reg | b_adv;
  assign d_adv   = d_valid_reg & (d_discard | b_free);
  assign d_drop  = d_valid_reg & d_discard;
  assign b_load  = d_adv & ~d_discard;
  assign pop     = pix.out_valid & pix.out_ready;
  // every pixel already admitted owns a FIFO slot, so stage C never has to stall
  assign occupancy = OW'(count_reg) + OW'(d_valid_reg) + OW'(b_valid_reg) + OW'(c_valid_reg);
  assign pix.in_ready = ~rst & (~d_valid_reg | d_adv) & (occupancy < OW'(DEPTH));
  assign accept  = pix.in_valid & pix.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid_reg <= 1'b0;
    end else if (accept) begin
      d_valid_reg <= 1'b1;
      d_data_reg  <= pix.in_data;
      d_cm_reg    <= pix.in_cm;
      d_offsx_reg <= pix.in_offsx;
      d_colr_reg  <= pix.in_colr;
      d_spd_reg   <= pix.in_spd;
      d_ecd_reg   <= pix.in_ecd;
      d_mesh_reg  <= pix.in_mesh;
      d_ccb_reg   <= pix.in_ccb;
      d_cg_reg    <= pix.in_cg;
      d_x_reg     <= pix.in_x;
      d_y_reg     <= pix.in_y;
      d_last_reg  <= pix.in_last;
    end else if (d_adv) begin
      d_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_reg <= 1'b0;
      bk_req_reg  <= 1'b0;
    end else if (b_load) begin
      b_valid_reg <= 1'b1;
      bk_req_reg  <= d_need;
      b_col_reg   <= d_col;
      b_calc_reg  <= d_calc;
      b_need_reg  <= d_need;
      b_ccb_reg   <= d_ccb_reg;
      b_cg_reg    <= d_cg_reg;
      b_x_reg     <= d_x_reg;
      b_y_reg     <= d_y_reg;
      b_last_reg  <= d_last_reg;
    end else if (b_adv) begin
      b_valid_reg <= 1'b0;
      bk_req_reg  <= 1'b0;
    end
  end

  assign pix.bk_req = bk_req_reg;
  assign pix.bk_x   = b_x_reg;
  assign pix.bk_y   = b_y_reg;

  // ---------------- Gouraud and colour calculation, one slice per channel ----------------
  // bk_data is consumed live on the BK_ACK edge, which is also the edge B hands over to C.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [GW-1:0] cg_ch;
    logic [4:0]    g_int, orig, bkc, gour, sel, a_ch, b_ch;
    logic [5:0]    gsum;

    assign cg_ch = b_cg_reg[gi*GW +: GW];
    if (GOUR_FRAC == 0) begin : g_nofrac
      assign g_int = cg_ch;
    end else begin : g_frac
      logic [GW:0] rnd;
      logic [5:0]  ip;
      assign rnd   = {1'b0, cg_ch} + ((GW+1)'(1) << (GOUR_FRAC - 1));
      assign ip    = rnd[GW:GOUR_FRAC];
      assign g_int = ip[5] ? 5'd31 : ip[4:0];
    end

    always_comb begin
      orig = b_col_reg[gi*5 +: 5];
      bkc  = pix.bk_data[gi*5 +: 5];
      gsum = {1'b0, orig} + {1'b0, g_int};
      gour = (gsum < 6'd16) ? 5'd0 : ((gsum > 6'd47) ? 5'd31 : 5'(gsum - 6'd16));
      sel  = b_ccb_reg[2] ? gour : orig;
      a_ch = 5'd0;
      b_ch = 5'd0;
      case (b_ccb_reg[1:0])
        2'b00: a_ch = sel;
        2'b01: b_ch = (b_ccb_reg[2] | ~pix.bk_data[15]) ? bkc : (bkc >> 1);
        2'b10: a_ch = sel >> 1;
        default: begin
          if (pix.bk_data[15]) begin
            a_ch = sel >> 1;
            b_ch = bkc >> 1;
          end else begin
            a_ch = sel;
          end
        end
      endcase
    end

    assign calc_rgb[gi*5 +: 5] = a_ch + b_ch;
  end

  always_comb begin
    case (b_ccb_reg[1:0])
      2'b01:   calc_msb = pix.bk_data[15];
      2'b11:   calc_msb = pix.bk_data[15] | b_col_reg[15];
      default: calc_msb = b_col_reg[15];
    endcase
    c_next = b_calc_reg ? {calc_msb, calc_rgb} : b_col_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_reg <= 1'b0;
    end else begin
      c_valid_reg <= b_adv;
      c_data_reg  <= c_next[PIX_W-1:0];
      c_x_reg     <= b_x_reg;
      c_y_reg     <= b_y_reg;
      c_last_reg  <= b_last_reg;
    end
  end

  // ---------------- output FIFO ----------------
  always_ff @(posedge clk) begin
    if (c_valid_reg)
      fifo_mem[wr_ptr_reg] <= {c_last_reg, c_x_reg, c_y_reg, c_data_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (c_valid_reg)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(c_valid_reg) - (AW+1)'(pop);
    end
  end

  assign head          = fifo_mem[rd_ptr_reg];
  assign pix.out_valid = (count_reg != '0);
  assign pix.out_data  = head[PIX_W-1:0];
  assign pix.out_y     = head[PIX_W +: 9];
  assign pix.out_x     = head[PIX_W+9 +: 10];

  // ---------------- counters and completion ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out_reg  <= '0;
      pix_disc_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      if (clr)
        pix_out_reg <= '0;
      else if (pop)
        pix_out_reg <= pix_out_reg + 16'd1;
      if (clr)
        pix_disc_reg <= '0;
      else if (d_drop)
        pix_disc_reg <= pix_disc_reg + 16'd1;
      done_reg <= (pop & head[EW-1]) | (d_drop & d_last_reg);
    end
  end

  assign pix_out  = pix_out_reg;
  assign pix_disc = pix_disc_reg;
  assign done     = done_reg;
endmodule

// File: tb/tb_vdp1_pix_color_pipe.sv
// Directed bench for vdp1_pix_color_pipe: decode, discard, background read, Gouraud,
// backpressure, counters, DONE and mid-operation reset, all with hand-computed results.
module tb_vdp1_pix_color_pipe;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, clr, done;
  logic [15:0] pix_out, pix_disc;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  vdp1_pix_color_pipe_if #(.PIX_W(16), .GOUR_FRAC(0)) bus ();

  vdp1_pix_color_pipe #(.DEPTH(DEPTH), .PIX_W(16), .GOUR_FRAC(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .pix      (bus.slave),
    .clr      (clr),
    .pix_out  (pix_out),
    .pix_disc (pix_disc),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix_defaults();
    bus.in_cm = 3'd0;    bus.in_data = 16'h0; bus.in_offsx = 2'd0; bus.in_colr = 16'h0;
    bus.in_spd = 1'b0;   bus.in_ecd = 1'b0;   bus.in_mesh = 1'b0;  bus.in_ccb = 3'd0;
    bus.in_cg = 15'h0;   bus.in_x = 10'd0;    bus.in_y = 9'd0;     bus.in_last = 1'b0;
  endtask

  task automatic push();
    int n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    $display("[TB] push cm=%0d data=%h x=%0d y=%0d", bus.in_cm, bus.in_data, bus.in_x, bus.in_y);
  endtask

  task automatic push_bk(input logic [15:0] bkd);
    int n = 0;
    push();
    while (!bus.bk_req && n < 20) begin
      tick();
      n++;
    end
    chk("bk_req_seen", {31'd0, bus.bk_req}, 32'd1);
    bus.bk_ack = 1'b1;
    bus.bk_data = bkd;
    tick();
    bus.bk_ack = 1'b0;
    bus.bk_data = 16'h0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] d, input logic [9:0] x, input logic [8:0] y);
    int n = 0;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, d});
    chk({tag, "_x"}, {22'd0, bus.out_x}, {22'd0, x});
    chk({tag, "_y"}, {23'd0, bus.out_y}, {23'd0, y});
    $display("[TB] pop %s data=%h x=%0d y=%0d", tag, bus.out_data, bus.out_x, bus.out_y);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int acc_cnt;
    logic acc;
    logic seen_done;

    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.bk_ack = 1'b0; bus.bk_data = 16'h0;
    pix_defaults();
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_bk_req", {31'd0, bus.bk_req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pix_out", {16'd0, pix_out}, 32'd0);
    chk("rst_pix_disc", {16'd0, pix_disc}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // CM0 nibble decode and three-cycle latency
    bus.in_colr = 16'h1230; bus.in_data = 16'h5000; bus.in_x = 10'd10; bus.in_y = 9'd20;
    push();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("lat_basic", lat, 32'd3);
    pop_expect("cm0", 16'h1235, 10'd10, 9'd20);
    chk("pix_out_1", {16'd0, pix_out}, 32'd1);

    // transparency, end code, DONE on pop and on discard
    bus.in_data = 16'h0000;
    push();
    repeat (4) tick();
    chk("tp_no_out", {31'd0, bus.out_valid}, 32'd0);
    chk("tp_disc", {16'd0, pix_disc}, 32'd1);
    bus.in_data = 16'hF000;
    push();
    repeat (4) tick();
    chk("ec_disc", {16'd0, pix_disc}, 32'd2);
    bus.in_ecd = 1'b1; bus.in_last = 1'b1;
    push();
    pop_expect("ecd_on", 16'h123F, 10'd10, 9'd20);
    chk("done_pop", {31'd0, done}, 32'd1);
    tick();
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("pix_out_2", {16'd0, pix_out}, 32'd2);
    bus.in_ecd = 1'b0; bus.in_data = 16'h0000;
    push();
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    chk("done_disc", {31'd0, done}, 32'd1);
    tick();
    chk("done_disc_end", {31'd0, done}, 32'd0);

    // mesh, CM4 and CM2 byte decode
    pix_defaults();
    bus.in_cm = 3'd4; bus.in_colr = 16'h5600; bus.in_data = 16'h12AB; bus.in_offsx = 2'd2;
    bus.in_mesh = 1'b1; bus.in_x = 10'd3; bus.in_y = 9'd4;
    push();
    repeat (4) tick();
    chk("mesh_disc", {16'd0, pix_disc}, 32'd4);
    bus.in_x = 10'd2;
    push();
    pop_expect("cm4", 16'h56AB, 10'd2, 9'd4);
    bus.in_cm = 3'd2; bus.in_colr = 16'h5640; bus.in_offsx = 2'd0;
    push();
    pop_expect("cm2", 16'h5652, 10'd2, 9'd4);

    // CCB 011 with a background read acknowledged 4 cycles after the request
    pix_defaults();
    bus.in_cm = 3'd5; bus.in_data = 16'h83E0; bus.in_ccb = 3'd3; bus.in_x = 10'h155; bus.in_y = 9'h0AA;
    bus.in_valid = 1'b1;
    chk("bk_a_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    pix_defaults();
    bus.in_colr = 16'h4560; bus.in_data = 16'h0030; bus.in_offsx = 2'd2; bus.in_x = 10'd7; bus.in_y = 9'd8;
    tick();
    bus.in_valid = 1'b0;
    chk("bk_req_rise", {31'd0, bus.bk_req}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("bk_x_stable", {22'd0, bus.bk_x}, 32'h155);
      chk("bk_y_stable", {23'd0, bus.bk_y}, 32'h0AA);
      chk("bk_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("bk_req_held", {31'd0, bus.bk_req}, 32'd1);
      tick();
    end
    bus.bk_ack = 1'b1; bus.bk_data = 16'h801F;
    tick();
    bus.bk_ack = 1'b0; bus.bk_data = 16'h0;
    chk("bk_req_drop", {31'd0, bus.bk_req}, 32'd0);
    chk("bk_lat_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("bk_lat_7", {31'd0, bus.out_valid}, 32'd1);
    pop_expect("ccb011", 16'h81EF, 10'h155, 9'h0AA);
    pop_expect("behind_bk", 16'h4563, 10'd7, 9'd8);

    // Gouraud with saturation and clamp, half-luminance, background modes 001/101
    pix_defaults();
    bus.in_cm = 3'd5; bus.in_ccb = 3'd4;
    bus.in_data = 16'h8010; bus.in_cg = {5'd16, 5'd16, 5'd31};
    push();
    pop_expect("gour_add", 16'h801F, 10'd0, 9'd0);
    bus.in_data = 16'h801F;
    push();
    pop_expect("gour_sat", 16'h801F, 10'd0, 9'd0);
    bus.in_data = 16'h8000; bus.in_cg = {5'd16, 5'd16, 5'd0};
    push();
    pop_expect("gour_clamp", 16'h8000, 10'd0, 9'd0);
    bus.in_ccb = 3'd2; bus.in_data = 16'h83FF;
    push();
    pop_expect("half_orig", 16'h81EF, 10'd0, 9'd0);
    bus.in_ccb = 3'd1; bus.in_data = 16'h8000;
    push_bk(16'h801F);
    pop_expect("ccb001", 16'h800F, 10'd0, 9'd0);
    bus.in_ccb = 3'd5;
    push_bk(16'h801F);
    pop_expect("ccb101", 16'h801F, 10'd0, 9'd0);

    // clear counters, then backpressure with a full FIFO
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_pix_out", {16'd0, pix_out}, 32'd0);
    chk("clr_pix_disc", {16'd0, pix_disc}, 32'd0);
    pix_defaults();
    bus.in_cm = 3'd5;
    acc_cnt = 0;
    bus.in_data = 16'h8000; bus.in_x = 10'd0;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      acc = bus.in_ready;
      tick();
      if (acc) begin
        acc_cnt++;
        bus.in_data = 16'h8000 + 16'(acc_cnt);
        bus.in_x = 10'(acc_cnt);
      end
    end
    chk("bp_accepted", acc_cnt, DEPTH);
    chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      pop_expect("bp_order", 16'h8000 + 16'(j), 10'(j), 9'd0);
    chk("bp_pix_out", {16'd0, pix_out}, DEPTH);

    // CLR has priority over a same-cycle pop
    bus.in_data = 16'h8123;
    push();
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    bus.out_ready = 1'b1; clr = 1'b1;
    tick();
    bus.out_ready = 1'b0; clr = 1'b0;
    chk("clr_vs_pop", {16'd0, pix_out}, 32'd0);
    chk("clr_popped", {31'd0, bus.out_valid}, 32'd0);

    // reset while a background read is outstanding
    pix_defaults();
    bus.in_cm = 3'd5; bus.in_ccb = 3'd1; bus.in_data = 16'h8001; bus.in_last = 1'b1;
    push();
    n = 0;
    while (!bus.bk_req && n < 10) begin
      tick();
      n++;
    end
    chk("mid_bk_req", {31'd0, bus.bk_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", {31'd0, bus.bk_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    bus.bk_ack = 1'b1; bus.bk_data = 16'hFFFF;
    seen_done = 1'b0;
    tick();
    bus.bk_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen_done = seen_done | done | bus.out_valid;
      tick();
    end
    chk("rst_no_done_out", {31'd0, seen_done}, 32'd0);
    chk("rst_ack_ignored", {31'd0, bus.bk_req}, 32'd0);
    chk("rst_cnt_out", {16'd0, pix_out}, 32'd0);
    chk("rst_cnt_disc", {16'd0, pix_disc}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
